// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - Instruction queue between IF and ID with exception lock and WB flush.
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         if_valid_in,
    input  logic [31:0]                  if_PC_in,
    input  logic [31:0]                  if_Instruct_in,
    input  logic                         if_exception_in,
    input  logic [4:0]                   if_ExcCode_in,
    output logic                         iq_allowin_out,
    input  logic                         id_allowin_in,
    input  logic                         wb_ClrStpJmp_in,
    output logic                         iq_valid_out,
    output logic [31:0]                  iq_PC_out,
    output logic [31:0]                  iq_Instruct_out,
    output logic                         iq_exception_out,
    output logic [4:0]                   iq_ExcCode_out,
    output logic [$clog2(DEPTH):0]       iq_count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, LOCK} lock_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    lock_state_e   state_q, state_d;
    logic          push;
    logic          pop;
    entry_t        head;

    // A full queue never passes through, even when ID pops the same cycle.
    assign iq_allowin_out = (count_q != FULL) && (state_q == RUN);
    assign iq_valid_out   = (count_q != '0);
    assign push           = if_valid_in && iq_allowin_out && !wb_ClrStpJmp_in;
    assign pop            = iq_valid_out && id_allowin_in && !wb_ClrStpJmp_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (wb_ClrStpJmp_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            // Stop fetching after a faulting fetch until WB redirects.
            if (push && if_exception_in) state_d = LOCK;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: if_PC_in, inst: if_Instruct_in,
                                exc: if_exception_in, code: if_ExcCode_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = '0;
        if (iq_valid_out) head = mem_q[rd_ptr_q];
    end

    assign iq_PC_out        = head.pc;
    assign iq_Instruct_out  = head.inst;
    assign iq_exception_out = head.exc;
    assign iq_ExcCode_out   = head.code;
    assign iq_count_out     = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - Scoreboard bench for inst_queue.
module tb_inst_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        if_valid_in;
    logic [31:0] if_PC_in;
    logic [31:0] if_Instruct_in;
    logic        if_exception_in;
    logic [4:0]  if_ExcCode_in;
    logic        iq_allowin_out;
    logic        id_allowin_in;
    logic        wb_ClrStpJmp_in;
    logic        iq_valid_out;
    logic [31:0] iq_PC_out;
    logic [31:0] iq_Instruct_out;
    logic        iq_exception_out;
    logic [4:0]  iq_ExcCode_out;
    logic [2:0]  iq_count_out;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t sb_q[$];
    logic   lock_m   = 1'b0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_valid_in      (if_valid_in),
        .if_PC_in         (if_PC_in),
        .if_Instruct_in   (if_Instruct_in),
        .if_exception_in  (if_exception_in),
        .if_ExcCode_in    (if_ExcCode_in),
        .iq_allowin_out   (iq_allowin_out),
        .id_allowin_in    (id_allowin_in),
        .wb_ClrStpJmp_in  (wb_ClrStpJmp_in),
        .iq_valid_out     (iq_valid_out),
        .iq_PC_out        (iq_PC_out),
        .iq_Instruct_out  (iq_Instruct_out),
        .iq_exception_out (iq_exception_out),
        .iq_ExcCode_out   (iq_ExcCode_out),
        .iq_count_out     (iq_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        entry_t e;
        e = '{pc: 32'h0, inst: 32'h0, exc: 1'b0, code: 5'h0};
        if (sb_q.size() != 0) e = sb_q[0];
        check("valid",   {31'h0, iq_valid_out},     {31'h0, sb_q.size() != 0});
        check("count",   {29'h0, iq_count_out},     sb_q.size());
        check("allowin", {31'h0, iq_allowin_out},   {31'h0, (sb_q.size() != DEPTH) && !lock_m});
        check("pc",      iq_PC_out,                 e.pc);
        check("inst",    iq_Instruct_out,           e.inst);
        check("exc",     {31'h0, iq_exception_out}, {31'h0, e.exc});
        check("code",    {27'h0, iq_ExcCode_out},   {27'h0, e.code});
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic exc,
                        input logic [4:0] code, input logic ida, input logic fl,
                        output logic acc);
        logic   pop_m;
        entry_t e;
        if_valid_in     = v;
        if_PC_in        = pc;
        if_Instruct_in  = ~pc ^ 32'h1234_5678;
        if_exception_in = exc;
        if_ExcCode_in   = code;
        id_allowin_in   = ida;
        wb_ClrStpJmp_in = fl;
        #1;
        check_outputs();
        acc   = v && (sb_q.size() != DEPTH) && !lock_m && !fl;
        pop_m = (sb_q.size() != 0) && ida && !fl;
        e     = '{pc: pc, inst: ~pc ^ 32'h1234_5678, exc: exc, code: code};
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
            lock_m = 1'b0;
        end else begin
            if (pop_m) void'(sb_q.pop_front());
            if (acc) begin
                sb_q.push_back(e);
                if (exc) lock_m = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic        acc;
        logic [31:0] next_pc;
        rst_n = 1'b0;
        if_valid_in = 1'b0; if_PC_in = '0; if_Instruct_in = '0;
        if_exception_in = 1'b0; if_ExcCode_in = '0;
        id_allowin_in = 1'b0; wb_ClrStpJmp_in = 1'b0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, then a fifth offer must be refused.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hBFC0_0000 + 32'(i * 4), 1'b0, 5'h0, 1'b0, 1'b0, acc);
            check("fill_acc", {31'h0, acc}, 32'h1);
        end
        step(1'b1, 32'hBFC0_0010, 1'b0, 5'h0, 1'b0, 1'b0, acc);
        check("fifth_acc", {31'h0, acc}, 32'h0);

        // Wrap with concurrent push/pop; PC advances only when accepted.
        next_pc = 32'h10;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, next_pc, 1'b0, 5'h0, 1'b1, 1'b0, acc);
            if (acc) next_pc += 4;
        end

        // Drain, then lock on an exception entry.
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 5'h0, 1'b1, 1'b0, acc);
        step(1'b1, 32'h80, 1'b1, 5'h04, 1'b0, 1'b0, acc);
        check("exc_acc", {31'h0, acc}, 32'h1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h84 + 32'(i * 4), 1'b0, 5'h0, 1'b1, 1'b0, acc);

        // Flush with simultaneous push and pop at count=3.
        step(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i * 4), 1'b0, 5'h0, 1'b0, 1'b0, acc);
        step(1'b1, 32'h300, 1'b0, 5'h0, 1'b1, 1'b1, acc);
        step(1'b1, 32'hBFC0_0380, 1'b0, 5'h0, 1'b0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 1'b0, acc);

        // Asynchronous reset mid-cycle with two entries queued.
        step(1'b1, 32'h400, 1'b0, 5'h0, 1'b0, 1'b0, acc);
        if_valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'h0, iq_valid_out}, 32'h0);
        check("async_count", {29'h0, iq_count_out}, 32'h0);
        check("async_allow", {31'h0, iq_allowin_out}, 32'h1);
        check("async_pc", iq_PC_out, 32'h0);
        sb_q.delete();
        lock_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h500, 1'b0, 5'h0, 1'b0, 1'b0, acc);
        check("post_rst_acc", {31'h0, acc}, 32'h1);

        // Single-entry stream through an empty queue.
        step(1'b0, 32'h0, 1'b0, 5'h0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h600 + 32'(i * 4), 1'b0, 5'h0, 1'b1, 1'b0, acc);
            check("stream_cnt", {31'h0, iq_count_out <= 3'd1}, 32'h1);
        end

        // Random traffic including exceptions and flushes.
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
                 5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, acc);
        end
        step(1'b0, 32'h0, 1'b0, 5'h0, 1'b0, 1'b0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
